// File: rtl/video_win_pkg.sv
// Shared definitions for the video window layout scheduler.
// Holds layout mode and arbiter state encodings, geometry field widths,
// the packed geometry payload and the layout decode helpers.
package video_win_pkg;

    localparam int unsigned NUM_WIN = 4;
    localparam int unsigned GEOM_W  = 12;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned BUS_W   = NUM_WIN * GEOM_W;

    typedef enum logic [MODE_W-1:0] {
        MODE_SINGLE = 2'd0,
        MODE_QUAD   = 2'd1,
        MODE_PIP    = 2'd2,
        MODE_SBS    = 2'd3
    } layout_mode_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_ACK   = 2'd2
    } arb_state_e;

    // One channel's rectangle.
    typedef struct packed {
        logic [GEOM_W-1:0] left;
        logic [GEOM_W-1:0] top;
        logic [GEOM_W-1:0] width;
        logic [GEOM_W-1:0] height;
    } win_geom_t;

    // Full layout as driven onto the output buses; channel i sits at [12i+11:12i].
    typedef struct packed {
        logic [NUM_WIN-1:0] en;
        logic [BUS_W-1:0]   left;
        logic [BUS_W-1:0]   top;
        logic [BUS_W-1:0]   width;
        logic [BUS_W-1:0]   height;
    } win_layout_t;

    // Per-channel enable mask for a layout mode.
    function automatic logic [NUM_WIN-1:0] win_en_of(input layout_mode_e mode);
        logic [NUM_WIN-1:0] en;
        case (mode)
            MODE_SINGLE: en = 4'b0001;
            MODE_QUAD:   en = 4'b1111;
            MODE_PIP:    en = 4'b0011;
            MODE_SBS:    en = 4'b0011;
            default:     en = 4'b0001;
        endcase
        return en;
    endfunction

    // Rectangle of one channel; disabled channels come back all zero.
    function automatic win_geom_t win_geom_of(input layout_mode_e mode,
                                              input logic [SEL_W-1:0] ch,
                                              input logic [GEOM_W-1:0] h,
                                              input logic [GEOM_W-1:0] v);
        win_geom_t g;
        logic [GEOM_W-1:0] h2, v2, h4, v4;
        h2 = h >> 1;
        v2 = v >> 1;
        h4 = h >> 2;
        v4 = v >> 2;
        g  = '0;
        case (mode)
            MODE_SINGLE: begin
                if (ch == 2'd0) begin
                    g.width  = h;
                    g.height = v;
                end
            end
            MODE_QUAD: begin
                g.left   = ch[0] ? h2 : '0;
                g.top    = ch[1] ? v2 : '0;
                g.width  = h2;
                g.height = v2;
            end
            MODE_PIP: begin
                if (ch == 2'd0) begin
                    g.width  = h;
                    g.height = v;
                end else if (ch == 2'd1) begin
                    g.left   = h - h4;
                    g.top    = v - v4;
                    g.width  = h4;
                    g.height = v4;
                end
            end
            MODE_SBS: begin
                if (ch == 2'd0) begin
                    g.width  = h2;
                    g.height = v;
                end else if (ch == 2'd1) begin
                    g.left   = h2;
                    g.width  = h - h2;
                    g.height = v;
                end
            end
            default: g = '0;
        endcase
        return g;
    endfunction

    // Pack all channels of a mode into the output bus layout.
    function automatic win_layout_t win_layout_of(input layout_mode_e mode,
                                                  input logic [GEOM_W-1:0] h,
                                                  input logic [GEOM_W-1:0] v);
        win_layout_t lay;
        win_geom_t   g;
        lay    = '0;
        lay.en = win_en_of(mode);
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            g = win_geom_of(mode, SEL_W'(i), h, v);
            lay.left[i*GEOM_W +: GEOM_W]   = g.left;
            lay.top[i*GEOM_W +: GEOM_W]    = g.top;
            lay.width[i*GEOM_W +: GEOM_W]  = g.width;
            lay.height[i*GEOM_W +: GEOM_W] = g.height;
        end
        return lay;
    endfunction

endpackage

// File: rtl/video_win_rr_arb.sv
// Round-robin arbiter folding per-channel frame-start read requests onto
// one frame-buffer read port with a req/ack handshake.
// Optional watchdog (macro VIDEO_WIN_SCHED_WDOG_EN) releases a grant that
// never sees mem_read_ack after TIMEOUT_CYC cycles and flags sched_err.
// Ports:
//   video_clk, rst_n   clock, async active-low reset
//   win_read_req[4]    per-channel level requests, held until acked
//   win_en[4]          current channel enables (sampled in IDLE only)
//   mem_read_ack       read-engine acknowledge
//   win_read_ack[4]    one-hot, one-cycle acknowledge back to channels
//   mem_read_req       request to the read engine
//   mem_read_sel[2]    granted channel index
//   sched_err          sticky watchdog error (0 without the watchdog)
module video_win_rr_arb
    import video_win_pkg::*;
#(
`ifdef VIDEO_WIN_SCHED_WDOG_EN
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic               video_clk,
    input  logic               rst_n,
    input  logic [NUM_WIN-1:0] win_read_req,
    input  logic [NUM_WIN-1:0] win_en,
    input  logic               mem_read_ack,
    output logic [NUM_WIN-1:0] win_read_ack,
    output logic               mem_read_req,
    output logic [SEL_W-1:0]   mem_read_sel,
    output logic               sched_err
);

    arb_state_e         state_q, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               req_nxt;
    logic [NUM_WIN-1:0] ack_nxt;
    logic [NUM_WIN-1:0] req_eff;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   scan_idx;

`ifdef VIDEO_WIN_SCHED_WDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wdog_cnt, wdog_cnt_nxt;
    logic             err_q, err_nxt;
    assign sched_err = err_q;
`else
    assign sched_err = 1'b0;
`endif

    // A channel whose ack is on the wire this cycle is not re-granted.
    assign req_eff = win_read_req & ~win_read_ack;

    // First pending request scanning upward from rr_ptr, wrapping 3->0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NUM_WIN; k++) begin
            scan_idx = rr_ptr + SEL_W'(k);
            if (!pick_found && req_eff[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state_q;
        rr_ptr_nxt = rr_ptr;
        sel_nxt    = mem_read_sel;
        req_nxt    = mem_read_req;
        ack_nxt    = '0;
`ifdef VIDEO_WIN_SCHED_WDOG_EN
        wdog_cnt_nxt = '0;
        err_nxt      = err_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    sel_nxt = pick_idx;
                    if (win_en[pick_idx]) begin
                        req_nxt   = 1'b1;
                        state_nxt = ARB_GRANT;
                    end else begin
                        // Disabled channel is acked without touching memory.
                        state_nxt = ARB_ACK;
                    end
                end
            end
            ARB_GRANT: begin
                if (mem_read_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = ARB_ACK;
                end
`ifdef VIDEO_WIN_SCHED_WDOG_EN
                else if (wdog_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = ARB_ACK;
                end else begin
                    wdog_cnt_nxt = wdog_cnt + CNT_W'(1);
                end
`endif
            end
            ARB_ACK: begin
                ack_nxt    = NUM_WIN'(1) << mem_read_sel;
                rr_ptr_nxt = mem_read_sel + SEL_W'(1);
                state_nxt  = ARB_IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            rr_ptr       <= '0;
            mem_read_sel <= '0;
            mem_read_req <= 1'b0;
            win_read_ack <= '0;
`ifdef VIDEO_WIN_SCHED_WDOG_EN
            wdog_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            mem_read_sel <= sel_nxt;
            mem_read_req <= req_nxt;
            win_read_ack <= ack_nxt;
`ifdef VIDEO_WIN_SCHED_WDOG_EN
            wdog_cnt     <= wdog_cnt_nxt;
            err_q        <= err_nxt;
`endif
        end
    end

endmodule

// File: rtl/video_win_layout_sched.sv
// Window layout controller and read scheduler for four display channels.
// A strobed layout mode is shadowed and applied only at a vsync falling
// edge; geometry and enables follow one cycle later. Frame-start read
// requests are arbitrated round-robin by video_win_rr_arb.
// Optional watchdog: define VIDEO_WIN_SCHED_WDOG_EN (adds TIMEOUT_CYC).
// Ports:
//   video_clk, rst_n          clock, async active-low reset
//   timing_vs                 vertical sync
//   layout_mode/layout_valid  requested mode and capture strobe
//   layout_pending            captured mode not yet applied
//   win_en, win_left/top/width/height   per-channel geometry (12b fields)
//   win_read_req/win_read_ack channel-side handshake
//   mem_read_req/sel/ack      read-engine handshake
//   sched_err                 sticky watchdog error
module video_win_layout_sched
    import video_win_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned V_ACTIVE = 1080
`ifdef VIDEO_WIN_SCHED_WDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic               video_clk,
    input  logic               rst_n,
    input  logic               timing_vs,
    input  logic [MODE_W-1:0]  layout_mode,
    input  logic               layout_valid,
    output logic               layout_pending,
    output logic [NUM_WIN-1:0] win_en,
    output logic [BUS_W-1:0]   win_left,
    output logic [BUS_W-1:0]   win_top,
    output logic [BUS_W-1:0]   win_width,
    output logic [BUS_W-1:0]   win_height,
    input  logic [NUM_WIN-1:0] win_read_req,
    output logic [NUM_WIN-1:0] win_read_ack,
    output logic               mem_read_req,
    output logic [SEL_W-1:0]   mem_read_sel,
    input  logic               mem_read_ack,
    output logic               sched_err
);

    localparam logic [GEOM_W-1:0] H_G = GEOM_W'(H_ACTIVE);
    localparam logic [GEOM_W-1:0] V_G = GEOM_W'(V_ACTIVE);

    logic         vs_d;
    logic         frame_bound_c;
    layout_mode_e pending_mode;
    layout_mode_e active_mode;
    win_layout_t  layout_q;

    assign frame_bound_c = vs_d & ~timing_vs;

    // Mode shadowing: capture on strobe, apply at the frame boundary.
    // A strobe coinciding with the boundary stays pending for the next one.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d           <= 1'b0;
            pending_mode   <= MODE_SINGLE;
            active_mode    <= MODE_SINGLE;
            layout_pending <= 1'b0;
        end else begin
            vs_d <= timing_vs;
            if (frame_bound_c && layout_pending) begin
                active_mode <= pending_mode;
            end
            if (layout_valid) begin
                pending_mode   <= layout_mode_e'(layout_mode);
                layout_pending <= 1'b1;
            end else if (frame_bound_c) begin
                layout_pending <= 1'b0;
            end
        end
    end

    // Registered geometry decode of the active mode.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            layout_q <= win_layout_of(MODE_SINGLE, H_G, V_G);
        end else begin
            layout_q <= win_layout_of(active_mode, H_G, V_G);
        end
    end

    assign win_en     = layout_q.en;
    assign win_left   = layout_q.left;
    assign win_top    = layout_q.top;
    assign win_width  = layout_q.width;
    assign win_height = layout_q.height;

    video_win_rr_arb
`ifdef VIDEO_WIN_SCHED_WDOG_EN
        #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_arb (
        .video_clk    (video_clk),
        .rst_n        (rst_n),
        .win_read_req (win_read_req),
        .win_en       (win_en),
        .mem_read_ack (mem_read_ack),
        .win_read_ack (win_read_ack),
        .mem_read_req (mem_read_req),
        .mem_read_sel (mem_read_sel),
        .sched_err    (sched_err)
    );

endmodule

// File: tb/tb_video_win_layout_sched.sv
// Directed and randomized bench for video_win_layout_sched with a
// behavioural layout / round-robin reference model.
`ifdef VIDEO_WIN_SCHED_WDOG_EN
`define TB_DUT_PARAMS .H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYC(16)
`else
`define TB_DUT_PARAMS .H_ACTIVE(H), .V_ACTIVE(V)
`endif

module tb_video_win_layout_sched;

    localparam int H = 1920;
    localparam int V = 1080;

    logic        video_clk = 1'b0;
    logic        rst_n;
    logic        timing_vs;
    logic [1:0]  layout_mode;
    logic        layout_valid;
    logic        layout_pending;
    logic [3:0]  win_en;
    logic [47:0] win_left, win_top, win_width, win_height;
    logic [3:0]  win_read_req;
    logic [3:0]  win_read_ack;
    logic        mem_read_req;
    logic [1:0]  mem_read_sel;
    logic        mem_read_ack;
    logic        sched_err;

    int checks = 0;
    int errors = 0;
    int cur_mode = 0;
    int pend_mode = 0;
    bit pend = 1'b0;
    int exp_ptr = 0;
    int first, hold, nstrobe;
    bit got;

    always #5 video_clk = ~video_clk;

    video_win_layout_sched #(`TB_DUT_PARAMS) dut (
        .video_clk      (video_clk),
        .rst_n          (rst_n),
        .timing_vs      (timing_vs),
        .layout_mode    (layout_mode),
        .layout_valid   (layout_valid),
        .layout_pending (layout_pending),
        .win_en         (win_en),
        .win_left       (win_left),
        .win_top        (win_top),
        .win_width      (win_width),
        .win_height     (win_height),
        .win_read_req   (win_read_req),
        .win_read_ack   (win_read_ack),
        .mem_read_req   (mem_read_req),
        .mem_read_sel   (mem_read_sel),
        .mem_read_ack   (mem_read_ack),
        .sched_err      (sched_err)
    );

    function automatic logic [3:0] model_en(input int mode);
        case (mode)
            0:       return 4'b0001;
            1:       return 4'b1111;
            default: return 4'b0011;
        endcase
    endfunction

    // f: 0=left 1=top 2=width 3=height, packed across the four channels.
    function automatic logic [47:0] model_geom(input int mode, input int f);
        logic [47:0] v = '0;
        int g[4];
        for (int ch = 0; ch < 4; ch++) begin
            g = '{0, 0, 0, 0};
            case (mode)
                0: if (ch == 0) g = '{0, 0, H, V};
                1: g = '{(ch % 2) * (H / 2), (ch / 2) * (V / 2), H / 2, V / 2};
                2: if (ch == 0) g = '{0, 0, H, V};
                   else if (ch == 1) g = '{H - H / 4, V - V / 4, H / 4, V / 4};
                default: if (ch == 0) g = '{0, 0, H / 2, V};
                   else if (ch == 1) g = '{H / 2, 0, H - H / 2, V};
            endcase
            v[ch*12 +: 12] = 12'(g[f]);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_layout();
        chk("win_en", 48'(win_en), 48'(model_en(cur_mode)));
        chk("win_left", win_left, model_geom(cur_mode, 0));
        chk("win_top", win_top, model_geom(cur_mode, 1));
        chk("win_width", win_width, model_geom(cur_mode, 2));
        chk("win_height", win_height, model_geom(cur_mode, 3));
    endtask

    task automatic strobe(input int mode);
        layout_mode  = 2'(mode);
        layout_valid = 1'b1;
        tick();
        layout_valid = 1'b0;
        pend      = 1'b1;
        pend_mode = mode;
        chk("pending_set", 48'(layout_pending), 48'(1));
        chk("en_unchanged", 48'(win_en), 48'(model_en(cur_mode)));
    endtask

    // vsync pulse; geometry must follow two cycles after the falling edge.
    task automatic frame();
        int old_mode = cur_mode;
        timing_vs = 1'b1;
        repeat (3) tick();
        timing_vs = 1'b0;
        tick();
        if (pend) begin
            cur_mode = pend_mode;
            pend     = 1'b0;
        end
        chk("pending_clr", 48'(layout_pending), 48'(0));
        chk("en_one_cycle", 48'(win_en), 48'(model_en(old_mode)));
        tick();
        check_layout();
    endtask

    // Raise a request set once; each channel drops on its ack. The model
    // predicts the full ack order from the round-robin rule.
    task automatic run_round(input logic [3:0] r, input int lat_fixed);
        int q[$];
        int p, c, hold_r, lat;
        logic [3:0] rem, en;
        bit seen;
        rem = r;
        p   = exp_ptr;
        while (rem != 4'b0) begin
            c = p;
            for (int k = 0; k < 4; k++) begin
                c = (p + k) % 4;
                if (rem[c]) break;
            end
            q.push_back(c);
            rem[c] = 1'b0;
            p = (c + 1) % 4;
        end
        en           = model_en(cur_mode);
        win_read_req = r;
        hold_r       = 0;
        seen         = 1'b0;
        lat          = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
        for (int cyc = 0; cyc < 300 && q.size() > 0; cyc++) begin
            tick();
            mem_read_ack = 1'b0;
            if (mem_read_req) begin
                seen = 1'b1;
                hold_r++;
                chk("mem_read_sel", 48'(mem_read_sel), 48'(q[0]));
                if (hold_r == lat) mem_read_ack = 1'b1;
            end
            if (win_read_ack != 4'b0) begin
                chk("win_read_ack", 48'(win_read_ack), 48'(4'b0001 << q[0]));
                chk("mem_req_used", 48'(seen), 48'(en[q[0]]));
                win_read_req = win_read_req & ~win_read_ack;
                exp_ptr = (q[0] + 1) % 4;
                void'(q.pop_front());
                seen   = 1'b0;
                hold_r = 0;
                lat    = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
        end
        chk("round_done", 48'(q.size()), 48'(0));
        mem_read_ack = 1'b0;
        win_read_req = 4'b0;
        repeat (2) tick();
        chk("ack_idle", 48'(win_read_ack), 48'(0));
        chk("req_idle", 48'(mem_read_req), 48'(0));
    endtask

    initial begin
        rst_n        = 1'b0;
        timing_vs    = 1'b0;
        layout_mode  = 2'd0;
        layout_valid = 1'b0;
        win_read_req = 4'b0;
        mem_read_ack = 1'b0;
        repeat (3) @(posedge video_clk);
        @(negedge video_clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        check_layout();
        chk("rst_pending", 48'(layout_pending), 48'(0));
        chk("rst_mem_req", 48'(mem_read_req), 48'(0));
        chk("rst_ack", 48'(win_read_ack), 48'(0));
        chk("rst_err", 48'(sched_err), 48'(0));

        // Quad mode strobed mid-frame
        tick();
        strobe(1);
        repeat (2) tick();
        check_layout();
        frame();

        // Last write wins: PIP then SBS in one frame
        strobe(2);
        tick();
        strobe(3);
        frame();

        // Strobe on the boundary cycle is held for the following boundary
        timing_vs = 1'b1;
        repeat (3) tick();
        layout_mode  = 2'd2;
        layout_valid = 1'b1;
        timing_vs    = 1'b0;
        tick();
        layout_valid = 1'b0;
        tick();
        chk("same_cycle_pending", 48'(layout_pending), 48'(1));
        check_layout();
        pend      = 1'b1;
        pend_mode = 2;
        frame();

        // Random layout strobes, including frames with none
        for (int it = 0; it < 8; it++) begin
            nstrobe = int'($urandom_range(0, 3));
            for (int s = 0; s < nstrobe; s++) begin
                strobe(int'($urandom_range(0, 3)));
                repeat (int'($urandom_range(0, 2))) tick();
            end
            frame();
        end

        // Quad, all four requesting, ack two cycles after each request
        strobe(1);
        frame();
        run_round(4'b1111, 2);
        run_round(4'b1111, 2);

`ifdef VIDEO_WIN_SCHED_WDOG_EN
        // Watchdog: first grant never acked
        first = exp_ptr;
        win_read_req = (4'b0001 << first) | (4'b0001 << ((first + 1) % 4));
        hold = 0;
        got  = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            tick();
            if (mem_read_req) hold++;
            if (win_read_ack != 4'b0) begin
                got = 1'b1;
                chk("wd_ack", 48'(win_read_ack), 48'(4'b0001 << first));
                win_read_req = win_read_req & ~win_read_ack;
            end
        end
        chk("wd_fired", 48'(got), 48'(1));
        chk("wd_len", 48'(hold), 48'(16));
        chk("wd_err", 48'(sched_err), 48'(1));
        exp_ptr = (first + 1) % 4;
        run_round(win_read_req, 2);
        chk("wd_sticky", 48'(sched_err), 48'(1));
`endif

        // Disabled channel is acked without a memory request
        strobe(0);
        frame();
        run_round(4'b0100, 2);

        // Random modes, request sets and ack latencies
        for (int it = 0; it < 8; it++) begin
            strobe(int'($urandom_range(0, 3)));
            frame();
            run_round(4'($urandom_range(1, 15)), 0);
        end
`ifndef VIDEO_WIN_SCHED_WDOG_EN
        chk("err_tied", 48'(sched_err), 48'(0));
`endif

        // Reset in the middle of a grant
        win_read_req = 4'b0001;
        got = 1'b0;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            tick();
            if (mem_read_req) got = 1'b1;
        end
        chk("grant_before_rst", 48'(got), 48'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", 48'(mem_read_req), 48'(0));
        chk("rst_async_ack", 48'(win_read_ack), 48'(0));
        chk("rst_async_en", 48'(win_en), 48'(4'b0001));
        win_read_req = 4'b0;
        @(negedge video_clk);
        rst_n     = 1'b1;
        cur_mode  = 0;
        pend      = 1'b0;
        exp_ptr   = 0;
        tick();
        check_layout();
        chk("post_rst_err", 48'(sched_err), 48'(0));
        run_round(4'b1001, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`undef TB_DUT_PARAMS
